// File: rtl/regfile_sb_pkg.sv
// Shared helpers for the scoreboarded register file.
//   addrWidth     : address width for a given register count (never below 1)
//   isValidTarget : whether an address names a real, writable register
//   MAX_READ_PORTS: upper bound on the number of read ports
package regfile_sb_pkg;

    localparam int MAX_READ_PORTS = 4;

    function automatic int addrWidth(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Addresses beyond the array, and register 0 when it is hard-wired,
    // are neither stored, reserved nor reported busy.
    function automatic logic isValidTarget(input int unsigned addr,
                                           input int unsigned depth,
                                           input logic        zeroReg);
        return (addr < depth) && !(zeroReg && (addr == 0));
    endfunction

endpackage

// File: rtl/regfile_sb_readport.sv
// One combinational read port of regfile_sb.
//   readAddr  : register address for this port
//   words     : flattened register contents, register i at [i*WIDTH +: WIDTH]
//   busyVec   : per-register pending-write flags
//   writeFire : write enable already qualified by reset release
//   writeAddr : write address (for bypass compare)
//   writeData : write data (forwarded on bypass hit)
//   readData  : selected word, zero for invalid addresses
//   readBusy  : selected register has an outstanding write
module regfile_sb_readport
    import regfile_sb_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [AW-1:0]          readAddr,
    input  logic [DEPTH*WIDTH-1:0] words,
    input  logic [DEPTH-1:0]       busyVec,
    input  logic                   writeFire,
    input  logic [AW-1:0]          writeAddr,
    input  logic [WIDTH-1:0]       writeData,
    output logic [WIDTH-1:0]       readData,
    output logic                   readBusy
);

    logic             readValid;
    logic             writeValid;
    logic             bypassHit;
    logic [WIDTH-1:0] storedWord;
    logic             storedBusy;

    assign readValid  = isValidTarget(32'(readAddr), DEPTH, ZERO_REG != 0);
    assign writeValid = isValidTarget(32'(writeAddr), DEPTH, ZERO_REG != 0);
    assign bypassHit  = (BYPASS != 0) && writeFire && writeValid
                        && (readAddr == writeAddr);

    // Explicit compare mux so addresses past DEPTH never index outside words.
    always_comb begin
        storedWord = '0;
        storedBusy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (readAddr == AW'(i)) begin
                storedWord = words[i*WIDTH +: WIDTH];
                storedBusy = busyVec[i];
            end
        end
    end

    // A forwarded write is by definition the value the reader was waiting
    // for, so a bypass hit also reports not-busy.
    always_comb begin
        readData = '0;
        readBusy = 1'b0;
        if (!readValid) begin
            readData = '0;
            readBusy = 1'b0;
        end else if (bypassHit) begin
            readData = writeData;
            readBusy = 1'b0;
        end else begin
            readData = storedWord;
            readBusy = storedBusy;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with per-register busy scoreboard.
//   Clk, Reset_n    : clock (posedge) and asynchronous active-low reset
//   ReadRegister    : NREAD packed read addresses, port p at [p*AW +: AW]
//   ReadData        : NREAD packed read words, port p at [p*WIDTH +: WIDTH]
//   ReadBusy        : per-port flag, addressed register has a pending write
//   Stall           : OR of all ReadBusy bits
//   WriteRegister, WriteData, RegWrite : write port (clears busy)
//   Reserve, ReserveRegister           : mark a register busy at next edge
//   PendingCount    : registered number of busy registers
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int DEPTH    = 32,
    parameter  int NREAD    = 2,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int AW       = addrWidth(DEPTH)
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic [NREAD*AW-1:0]    ReadRegister,
    output logic [NREAD*WIDTH-1:0] ReadData,
    output logic [NREAD-1:0]       ReadBusy,
    output logic                   Stall,
    input  logic [AW-1:0]          WriteRegister,
    input  logic [WIDTH-1:0]       WriteData,
    input  logic                   RegWrite,
    input  logic                   Reserve,
    input  logic [AW-1:0]          ReserveRegister,
    output logic [AW:0]            PendingCount
);

    logic [DEPTH-1:0][WIDTH-1:0] regs;
    logic [DEPTH-1:0]            busy;
    logic [DEPTH-1:0]            busyNext;
    logic                        writeFire;
    logic                        writeValid;
    logic                        reserveValid;

    function automatic logic [AW:0] popCount(input logic [DEPTH-1:0] v);
        logic [AW:0] cnt;
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + (AW+1)'(v[i]);
        end
        return cnt;
    endfunction

    // Gating with Reset_n keeps the bypass path quiet while reset is held,
    // so every read port shows zero during reset.
    assign writeFire    = RegWrite & Reset_n;
    assign writeValid   = writeFire
                          && isValidTarget(32'(WriteRegister), DEPTH, ZERO_REG != 0);
    assign reserveValid = Reserve & Reset_n
                          && isValidTarget(32'(ReserveRegister), DEPTH, ZERO_REG != 0);

    // Reserve is applied after the write clear so that a simultaneous
    // reserve and write to one register leaves it busy.
    always_comb begin
        busyNext = busy;
        for (int i = 0; i < DEPTH; i++) begin
            if (writeValid && (WriteRegister == AW'(i))) begin
                busyNext[i] = 1'b0;
            end
            if (reserveValid && (ReserveRegister == AW'(i))) begin
                busyNext[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            regs         <= '0;
            busy         <= '0;
            PendingCount <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (writeValid && (WriteRegister == AW'(i))) begin
                    regs[i] <= WriteData;
                end
            end
            busy         <= busyNext;
            PendingCount <= popCount(busyNext);
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : gRead
        regfile_sb_readport #(
            .WIDTH    (WIDTH),
            .DEPTH    (DEPTH),
            .AW       (AW),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) uPort (
            .readAddr  (ReadRegister[p*AW +: AW]),
            .words     (regs),
            .busyVec   (busy),
            .writeFire (writeFire),
            .writeAddr (WriteRegister),
            .writeData (WriteData),
            .readData  (ReadData[p*WIDTH +: WIDTH]),
            .readBusy  (ReadBusy[p])
        );
    end

    assign Stall = |ReadBusy;

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    localparam int K_DATA  = 0;
    localparam int K_BUSY  = 1;
    localparam int K_STALL = 2;
    localparam int K_PCNT  = 3;

    logic clk;
    logic Reset_n;

    // dut 0: default build (32x32, 2 ports, zero reg, bypass)
    logic [9:0]  aRR;
    logic [63:0] aRD;
    logic [1:0]  aRB;
    logic        aSt;
    logic [4:0]  aWR;
    logic [31:0] aWD;
    logic        aWE;
    logic        aRes;
    logic [4:0]  aResR;
    logic [5:0]  aPC;

    // dut 1: DEPTH=24, no zero reg, no bypass
    logic [9:0]  bRR;
    logic [63:0] bRD;
    logic [1:0]  bRB;
    logic        bSt;
    logic [4:0]  bWR;
    logic [31:0] bWD;
    logic        bWE;
    logic        bRes;
    logic [4:0]  bResR;
    logic [5:0]  bPC;

    // dut 2: WIDTH=16, DEPTH=8, NREAD=4
    logic [11:0] cRR;
    logic [63:0] cRD;
    logic [3:0]  cRB;
    logic        cSt;
    logic [2:0]  cWR;
    logic [15:0] cWD;
    logic        cWE;
    logic        cRes;
    logic [2:0]  cResR;
    logic [3:0]  cPC;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        int          dut;
        int          kind;
        int          port;
        logic [31:0] val;
    } exp_t;

    exp_t expQ[$];

    regfile_sb uA (
        .Clk(clk), .Reset_n(Reset_n), .ReadRegister(aRR), .ReadData(aRD),
        .ReadBusy(aRB), .Stall(aSt), .WriteRegister(aWR), .WriteData(aWD),
        .RegWrite(aWE), .Reserve(aRes), .ReserveRegister(aResR), .PendingCount(aPC)
    );

    regfile_sb #(.WIDTH(32), .DEPTH(24), .NREAD(2), .ZERO_REG(0), .BYPASS(0)) uB (
        .Clk(clk), .Reset_n(Reset_n), .ReadRegister(bRR), .ReadData(bRD),
        .ReadBusy(bRB), .Stall(bSt), .WriteRegister(bWR), .WriteData(bWD),
        .RegWrite(bWE), .Reserve(bRes), .ReserveRegister(bResR), .PendingCount(bPC)
    );

    regfile_sb #(.WIDTH(16), .DEPTH(8), .NREAD(4), .ZERO_REG(1), .BYPASS(1)) uC (
        .Clk(clk), .Reset_n(Reset_n), .ReadRegister(cRR), .ReadData(cRD),
        .ReadBusy(cRB), .Stall(cSt), .WriteRegister(cWR), .WriteData(cWD),
        .RegWrite(cWE), .Reserve(cRes), .ReserveRegister(cResR), .PendingCount(cPC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] observe(input int dut, input int kind, input int port);
        logic [31:0] r;
        r = '0;
        case (dut)
            0: case (kind)
                K_DATA:  r = aRD[port*32 +: 32];
                K_BUSY:  r = {31'b0, aRB[port]};
                K_STALL: r = {31'b0, aSt};
                default: r = {26'b0, aPC};
            endcase
            1: case (kind)
                K_DATA:  r = bRD[port*32 +: 32];
                K_BUSY:  r = {31'b0, bRB[port]};
                K_STALL: r = {31'b0, bSt};
                default: r = {26'b0, bPC};
            endcase
            default: case (kind)
                K_DATA:  r = {16'b0, cRD[port*16 +: 16]};
                K_BUSY:  r = {31'b0, cRB[port]};
                K_STALL: r = {31'b0, cSt};
                default: r = {28'b0, cPC};
            endcase
        endcase
        return r;
    endfunction

    task automatic pushExp(input string n, input int d, input int k, input int p,
                           input logic [31:0] v);
        exp_t e;
        e.name = n; e.dut = d; e.kind = k; e.port = p; e.val = v;
        expQ.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic setReadA(input int p, input logic [4:0] a);
        aRR[p*5 +: 5] = a;
    endtask

    task automatic setReadB(input int p, input logic [4:0] a);
        bRR[p*5 +: 5] = a;
    endtask

    task automatic setReadC(input int p, input logic [2:0] a);
        cRR[p*3 +: 3] = a;
    endtask

    task automatic idleAll();
        aWE = 0; aRes = 0; bWE = 0; bRes = 0; cWE = 0; cRes = 0;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [31:0] got;
        // state while the initial reset is still held
        setReadA(0, 5'd5);
        setReadB(0, 5'd5);
        #1;
        pushExp("reset_a_pcnt", 0, K_PCNT, 0, 32'd0);
        pushExp("reset_a_data", 0, K_DATA, 0, 32'd0);
        pushExp("reset_b_pcnt", 1, K_PCNT, 0, 32'd0);
        pushExp("reset_c_pcnt", 2, K_PCNT, 0, 32'd0);
        pushExp("reset_a_stall", 0, K_STALL, 0, 32'd0);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            got = observe(e.dut, e.kind, e.port);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        repeat (2) @(posedge clk);
        #2 Reset_n = 1'b1;
        tick();
        aWR = 5'd5; aWD = 32'hDEADBEEF; aWE = 1; aRes = 1; aResR = 5'd6;
        tick();
        idleAll();
        setReadA(0, 5'd5);
        setReadA(1, 5'd6);
        #1;
        pushExp("pre_reset_r5", 0, K_DATA, 0, 32'hDEADBEEF);
        pushExp("pre_reset_busy_r6", 0, K_BUSY, 1, 32'd1);
        pushExp("pre_reset_pcnt", 0, K_PCNT, 0, 32'd1);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            got = observe(e.dut, e.kind, e.port);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        // asynchronous assertion mid-cycle, with a write attempt held active
        #1 Reset_n = 1'b0;
        aWE = 1; aWR = 5'd5; aWD = 32'h01234567;
        #1;
        pushExp("midreset_r5", 0, K_DATA, 0, 32'd0);
        pushExp("midreset_busy_r6", 0, K_BUSY, 1, 32'd0);
        pushExp("midreset_stall", 0, K_STALL, 0, 32'd0);
        pushExp("midreset_pcnt", 0, K_PCNT, 0, 32'd0);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            got = observe(e.dut, e.kind, e.port);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        tick();
        pushExp("inreset_write_ignored", 0, K_DATA, 0, 32'd0);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            got = observe(e.dut, e.kind, e.port);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        idleAll();
        Reset_n = 1'b1;
        tick();
    endtask

    task automatic test_zero_reg();
        exp_t e;
        logic [31:0] got;
        aWR = 5'd0; aWD = 32'hFFFFFFFF; aWE = 1; aRes = 1; aResR = 5'd0;
        setReadA(0, 5'd0); setReadA(1, 5'd0);
        bWR = 5'd0; bWD = 32'hFFFFFFFF; bWE = 1;
        setReadB(0, 5'd0); setReadB(1, 5'd0);
        #1;
        pushExp("zero_no_bypass", 0, K_DATA, 0, 32'd0);
        pushExp("zero_busy_same_cycle", 0, K_BUSY, 1, 32'd0);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            got = observe(e.dut, e.kind, e.port);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        tick();
        idleAll();
        #1;
        pushExp("zero_r0_data", 0, K_DATA, 0, 32'd0);
        pushExp("zero_r0_busy", 0, K_BUSY, 0, 32'd0);
        pushExp("zero_r0_pcnt", 0, K_PCNT, 0, 32'd0);
        pushExp("nozero_r0_p0", 1, K_DATA, 0, 32'hFFFFFFFF);
        pushExp("nozero_r0_p1", 1, K_DATA, 1, 32'hFFFFFFFF);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            got = observe(e.dut, e.kind, e.port);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_bypass();
        exp_t e;
        logic [31:0] got;
        aWR = 5'd7; aWD = 32'h11111111; aWE = 1;
        bWR = 5'd7; bWD = 32'h11111111; bWE = 1;
        tick();
        aWD = 32'h12345678;
        bWD = 32'h12345678;
        setReadA(0, 5'd7); setReadA(1, 5'd7);
        setReadB(0, 5'd7); setReadB(1, 5'd7);
        #1;
        pushExp("bypass_p0", 0, K_DATA, 0, 32'h12345678);
        pushExp("bypass_p1", 0, K_DATA, 1, 32'h12345678);
        pushExp("nobypass_old_p0", 1, K_DATA, 0, 32'h11111111);
        pushExp("nobypass_old_p1", 1, K_DATA, 1, 32'h11111111);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            got = observe(e.dut, e.kind, e.port);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        tick();
        idleAll();
        #1;
        pushExp("bypass_stored", 0, K_DATA, 0, 32'h12345678);
        pushExp("nobypass_new_p0", 1, K_DATA, 0, 32'h12345678);
        pushExp("nobypass_new_p1", 1, K_DATA, 1, 32'h12345678);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            got = observe(e.dut, e.kind, e.port);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_scoreboard();
        exp_t e;
        logic [31:0] got;
        aRes = 1; aResR = 5'd3;
        tick();
        aResR = 5'd9;
        tick();
        idleAll();
        setReadA(0, 5'd3); setReadA(1, 5'd4);
        #1;
        pushExp("sb_pcnt_two", 0, K_PCNT, 0, 32'd2);
        pushExp("sb_busy_r3", 0, K_BUSY, 0, 32'd1);
        pushExp("sb_busy_r4", 0, K_BUSY, 1, 32'd0);
        pushExp("sb_stall", 0, K_STALL, 0, 32'd1);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            got = observe(e.dut, e.kind, e.port);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        aWE = 1; aWR = 5'd3; aWD = 32'h33333333;
        #1;
        pushExp("sb_wb_bypass_data", 0, K_DATA, 0, 32'h33333333);
        pushExp("sb_wb_bypass_busy", 0, K_BUSY, 0, 32'd0);
        pushExp("sb_wb_bypass_stall", 0, K_STALL, 0, 32'd0);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            got = observe(e.dut, e.kind, e.port);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        tick();
        idleAll();
        #1;
        pushExp("sb_r3_cleared", 0, K_BUSY, 0, 32'd0);
        pushExp("sb_pcnt_one", 0, K_PCNT, 0, 32'd1);
        pushExp("sb_r3_data", 0, K_DATA, 0, 32'h33333333);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            got = observe(e.dut, e.kind, e.port);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        // reserve and write the same register: reserve wins, data lands
        aRes = 1; aResR = 5'd9; aWE = 1; aWR = 5'd9; aWD = 32'hCAFE0009;
        tick();
        idleAll();
        setReadA(0, 5'd9);
        #1;
        pushExp("sb_same_busy", 0, K_BUSY, 0, 32'd1);
        pushExp("sb_same_data", 0, K_DATA, 0, 32'hCAFE0009);
        pushExp("sb_same_pcnt", 0, K_PCNT, 0, 32'd1);
        pushExp("sb_same_stall", 0, K_STALL, 0, 32'd1);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            got = observe(e.dut, e.kind, e.port);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        // reserve and write different registers: both take effect
        aRes = 1; aResR = 5'd10; aWE = 1; aWR = 5'd9; aWD = 32'h99999999;
        tick();
        idleAll();
        setReadA(1, 5'd10);
        #1;
        pushExp("sb_diff_r9_busy", 0, K_BUSY, 0, 32'd0);
        pushExp("sb_diff_r9_data", 0, K_DATA, 0, 32'h99999999);
        pushExp("sb_diff_r10_busy", 0, K_BUSY, 1, 32'd1);
        pushExp("sb_diff_pcnt", 0, K_PCNT, 0, 32'd1);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            got = observe(e.dut, e.kind, e.port);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_parametric();
        exp_t e;
        logic [31:0] got;
        logic [15:0] v;
        for (int i = 1; i <= 7; i++) begin
            cWE = 1; cWR = 3'(i); cWD = 16'hA000 + 16'(i * 16'h0111);
            tick();
        end
        idleAll();
        setReadC(0, 3'd1); setReadC(1, 3'd3); setReadC(2, 3'd5); setReadC(3, 3'd7);
        #1;
        for (int p = 0; p < 4; p++) begin
            v = 16'hA000 + 16'((2 * p + 1) * 16'h0111);
            pushExp($sformatf("par_odd_p%0d", p), 2, K_DATA, p, {16'b0, v});
        end
        pushExp("par_pcnt", 2, K_PCNT, 0, 32'd0);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            got = observe(e.dut, e.kind, e.port);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        setReadC(0, 3'd2); setReadC(1, 3'd4); setReadC(2, 3'd6); setReadC(3, 3'd0);
        #1;
        pushExp("par_even_p0", 2, K_DATA, 0, 32'h0000A222);
        pushExp("par_even_p1", 2, K_DATA, 1, 32'h0000A444);
        pushExp("par_even_p2", 2, K_DATA, 2, 32'h0000A666);
        pushExp("par_r0_p3", 2, K_DATA, 3, 32'h00000000);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            got = observe(e.dut, e.kind, e.port);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        // out-of-range handling in the DEPTH=24 build
        bWE = 1; bWR = 5'd23; bWD = 32'h23232323;
        tick();
        bWR = 5'd25; bWD = 32'h5555AAAA; bRes = 1; bResR = 5'd30;
        setReadB(0, 5'd25); setReadB(1, 5'd30);
        tick();
        idleAll();
        #1;
        pushExp("oor_read_data", 1, K_DATA, 0, 32'd0);
        pushExp("oor_read_busy", 1, K_BUSY, 1, 32'd0);
        pushExp("oor_pcnt", 1, K_PCNT, 0, 32'd0);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            got = observe(e.dut, e.kind, e.port);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        setReadB(1, 5'd23);
        #1;
        pushExp("last_reg_data", 1, K_DATA, 1, 32'h23232323);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            got = observe(e.dut, e.kind, e.port);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        logic [31:0] got;
        #1 Reset_n = 1'b0;
        #1 Reset_n = 1'b1;
        aRes = 1; cRes = 1;
        for (int i = 1; i <= 31; i++) begin
            aResR = 5'(i);
            cResR = (i <= 7) ? 3'(i) : 3'd0;
            tick();
        end
        idleAll();
        setReadA(0, 5'd31);
        #1;
        pushExp("sat_a_pcnt", 0, K_PCNT, 0, 32'd31);
        pushExp("sat_a_busy_r31", 0, K_BUSY, 0, 32'd1);
        pushExp("sat_c_pcnt", 2, K_PCNT, 0, 32'd7);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            got = observe(e.dut, e.kind, e.port);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        aRes = 1; aResR = 5'd5; cRes = 1; cResR = 3'd5;
        tick();
        idleAll();
        #1;
        pushExp("sat_a_repeat", 0, K_PCNT, 0, 32'd31);
        pushExp("sat_c_repeat", 2, K_PCNT, 0, 32'd7);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            got = observe(e.dut, e.kind, e.port);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
    endtask

    initial begin
        Reset_n = 1'b0;
        aRR = '0; aWR = '0; aWD = '0; aWE = 0; aRes = 0; aResR = '0;
        bRR = '0; bWR = '0; bWD = '0; bWE = 0; bRes = 0; bResR = '0;
        cRR = '0; cWR = '0; cWD = '0; cWE = 0; cRes = 0; cResR = '0;
        test_reset();
        test_zero_reg();
        test_bypass();
        test_scoreboard();
        test_parametric();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
